instr_register_pipe: RTL and testbench
======================================

# instr_register_pipe

Parametrised, handshaked instruction register: accepts opcode/operand transactions over a valid/ready write port, computes the result, and stores opcode, operands, result and status in a DEPTH-entry register file. Single-cycle ALU for ZERO/PASSA/PASSB/ADD/SUB/MULT; DIV/MOD run on an iterative divider that back-pressures the write port. It sits between the instruction source and the consumer, replacing the fixed 32-entry, always-ready register.

## Interface
- DATA_W, 32: operand width, signed two's complement; minimum 2.
- DEPTH, 32: number of entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH): pointer width (derived, not overridden).
- clk  in  1  clock, all state rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  write transaction offered.
- wr_ready  out  1  block can accept a transaction.
- opcode  in  3  ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
- operand_a, operand_b  in  DATA_W  signed operands.
- write_pointer  in  ADDR_W  destination entry.
- clear  in  1  synchronous: invalidate all entries.
- rd_en  in  1  read request.
- read_pointer  in  ADDR_W  entry to read, sampled with rd_en.
- rd_data_valid  out  1  read response strobe, one cycle.
- rd_hit  out  1  addressed entry holds a committed instruction.
- rd_opcode  out  3; rd_operand_a, rd_operand_b  out  DATA_W; rd_result  out  2*DATA_W  signed.
- rd_div_zero  out  1  stored entry was DIV/MOD with operand_b = 0.

## Operation
- Transfer occurs on an edge where wr_valid && wr_ready; opcode, operands and pointer are captured on that edge only.
- Result is always 2*DATA_W, sign-extended; ADD/SUB/MULT computed at full width, so no overflow; ZERO gives 0, PASSA/PASSB sign-extend the operand.
- DIV truncates toward zero; MOD takes the sign of operand_a (a = q*b + r). Divider: restoring, on magnitudes, with sign correction at commit. Most-negative / -1 gives +2^(DATA_W-1), representable in 2*DATA_W.
- Divide by zero (DIV or MOD with b = 0): result 0, div_zero = 1, handled as a single-cycle op with no divider use.
- Entry fields: valid, opcode, operand_a, operand_b, result, div_zero. A commit writes all fields and sets valid.
- FSM states: IDLE (wr_ready = 1) and DIVIDE (wr_ready = 0, DATA_W-iteration counter).
  - IDLE -> DIVIDE on accepted DIV/MOD with b != 0.
  - DIVIDE -> IDLE on the edge completing iteration DATA_W, which commits the entry.
- clear invalidates every entry (valid = 0, other fields kept). A commit on the same edge wins for its own entry (left valid). clear does not abort an in-flight divide.
- Read of an invalid entry: rd_hit = 0; all rd_* fields 0.

## Timing
- Reset: every entry valid = 0 and fields 0; FSM IDLE; wr_ready = 0 while reset_n low, 1 from the first rising edge after release; rd_data_valid, rd_hit, all rd_* = 0.
- Non-divide op accepted at edge N: entry committed at edge N+1. wr_ready stays 1, so back-to-back transfers sustain one per cycle.
- DIV/MOD (b != 0) accepted at edge N: wr_ready low from after N until edge N+DATA_W; commit at edge N+DATA_W; wr_ready high after it (exactly DATA_W low cycles). wr_valid held while busy is not accepted.
- Read: rd_en sampled at edge M; rd_* registered, valid after M, rd_data_valid high for the cycle after M only.
- Read and commit to the same entry on the same edge: the read returns the pre-commit contents.
- Two consecutive commits to the same pointer: the last one wins.
- reset_n asserted mid-divide: the divide is aborted with no commit, and all entries are cleared.

## Test plan
- ADD a = -5, b = 3 to wp 4; read rp 4 -> rd_hit = 1, rd_result = 64'hFFFF_FFFF_FFFF_FFFE, rd_div_zero = 0, rd_data_valid is a 1-cycle pulse.
- MULT a = 32'h7FFF_FFFF, b = 2 -> rd_result = 64'h0000_0000_FFFF_FFFE; 32 back-to-back PASSA writes to wp 0..31 with wr_ready never low; readback matches.
- DIV -7/2 -> -3 and MOD -7%2 -> -1; wr_ready low exactly 32 cycles each; a held wr_valid ADD is accepted only after wr_ready returns high.
- DIV 9/0 -> result 0, rd_div_zero = 1, committed at edge N+1, wr_ready never low.
- Read unwritten rp 7 -> rd_hit = 0, fields 0; write wp 3, then assert clear together with a commit to wp 5 -> rp 3 misses, rp 5 hits.
- Assert reset_n at cycle 10 of a DIV -> no commit, all reads miss, wr_ready = 0 during reset and 1 one edge after release.

Source files
------------

// File: rtl/instr_register_pipe.sv
// Handshaked instruction register: single-cycle ALU ops commit one edge after
// acceptance; DIV/MOD run a restoring divider that holds wr_ready low meanwhile.
module instr_register_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            opcode,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [ADDR_W-1:0]     write_pointer,
    input  logic                  clear,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     read_pointer,
    output logic                  rd_data_valid,
    output logic                  rd_hit,
    output logic [2:0]            rd_opcode,
    output logic [DATA_W-1:0]     rd_operand_a,
    output logic [DATA_W-1:0]     rd_operand_b,
    output logic [2*DATA_W-1:0]   rd_result,
    output logic                  rd_div_zero
);

    localparam int unsigned RES_W = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        OP_ZERO  = 3'd0,
        OP_PASSA = 3'd1,
        OP_PASSB = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MULT  = 3'd5,
        OP_DIV   = 3'd6,
        OP_MOD   = 3'd7
    } op_t;

    typedef enum logic {IDLE, DIVIDE} state_t;

    typedef struct packed {
        logic              valid;
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [RES_W-1:0]  result;
        logic              div_zero;
    } entry_t;

    entry_t             entries_q [DEPTH];
    entry_t             entries_d [DEPTH];

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               stg_valid_q, stg_valid_d;
    logic [2:0]         stg_op_q, stg_op_d;
    logic [DATA_W-1:0]  stg_a_q, stg_a_d;
    logic [DATA_W-1:0]  stg_b_q, stg_b_d;
    logic [ADDR_W-1:0]  stg_ptr_q, stg_ptr_d;
    logic [DATA_W-1:0]  dvd_q, dvd_d;
    logic [DATA_W-1:0]  dvs_q, dvs_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               rd_valid_q, rd_valid_d;
    logic               rd_hit_q, rd_hit_d;
    logic [2:0]         rd_op_q, rd_op_d;
    logic [DATA_W-1:0]  rd_a_q, rd_a_d;
    logic [DATA_W-1:0]  rd_b_q, rd_b_d;
    logic [RES_W-1:0]   rd_res_q, rd_res_d;
    logic               rd_dz_q, rd_dz_d;

    logic               accept;
    logic               start_div;
    logic               div_done;
    logic               commit_en;
    entry_t             commit_entry;
    entry_t             rd_sel;

    logic [DATA_W:0]    rem_sh, rem_diff;
    logic               q_bit;
    logic [DATA_W-1:0]  rem_next, quo_next;
    logic [RES_W-1:0]   quo_ext, rem_ext, div_res;
    logic [RES_W-1:0]   a_ext, b_ext, alu_res;
    logic               alu_dz;

    assign accept    = wr_valid && ready_q;
    assign start_div = accept && (opcode == OP_DIV || opcode == OP_MOD) && (operand_b != '0);
    assign div_done  = (state_q == DIVIDE) && (cnt_q == CNT_W'(DATA_W - 1));
    assign commit_en = stg_valid_q || div_done;

    // One restoring step per cycle; dvd_q shifts out dividend bits and in quotient bits.
    always_comb begin
        rem_sh   = {rem_q, dvd_q[DATA_W-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        q_bit    = !rem_diff[DATA_W];
        rem_next = q_bit ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_next = {dvd_q[DATA_W-2:0], q_bit};
        quo_ext  = {{DATA_W{1'b0}}, quo_next};
        rem_ext  = {{DATA_W{1'b0}}, rem_next};
        if (stg_op_q == OP_MOD) begin
            div_res = stg_a_q[DATA_W-1] ? ('0 - rem_ext) : rem_ext;
        end else begin
            div_res = (stg_a_q[DATA_W-1] ^ stg_b_q[DATA_W-1]) ? ('0 - quo_ext) : quo_ext;
        end
    end

    always_comb begin
        a_ext   = {{DATA_W{stg_a_q[DATA_W-1]}}, stg_a_q};
        b_ext   = {{DATA_W{stg_b_q[DATA_W-1]}}, stg_b_q};
        alu_res = '0;
        alu_dz  = 1'b0;
        case (op_t'(stg_op_q))
            OP_ZERO:  alu_res = '0;
            OP_PASSA: alu_res = a_ext;
            OP_PASSB: alu_res = b_ext;
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB:   alu_res = a_ext - b_ext;
            OP_MULT:  alu_res = a_ext * b_ext;
            default:  alu_dz  = 1'b1;
        endcase
        commit_entry          = '0;
        commit_entry.valid    = 1'b1;
        commit_entry.op       = stg_op_q;
        commit_entry.a        = stg_a_q;
        commit_entry.b        = stg_b_q;
        commit_entry.result   = div_done ? div_res : alu_res;
        commit_entry.div_zero = div_done ? 1'b0 : alu_dz;
    end

    // Staging registers double as the operand hold for an in-flight divide.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        stg_valid_d = accept && !start_div;
        stg_op_d    = stg_op_q;
        stg_a_d     = stg_a_q;
        stg_b_d     = stg_b_q;
        stg_ptr_d   = stg_ptr_q;
        if (accept) begin
            stg_op_d  = opcode;
            stg_a_d   = operand_a;
            stg_b_d   = operand_b;
            stg_ptr_d = write_pointer;
        end
        case (state_q)
            IDLE: begin
                if (start_div) begin
                    state_d = DIVIDE;
                    cnt_d   = '0;
                    rem_d   = '0;
                    dvd_d   = operand_a[DATA_W-1] ? ('0 - operand_a) : operand_a;
                    dvs_d   = operand_b[DATA_W-1] ? ('0 - operand_b) : operand_b;
                end
            end
            default: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (div_done) state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (clear) entries_d[i].valid = 1'b0;
        end
        if (commit_en) entries_d[stg_ptr_q] = commit_entry;
    end

    always_comb begin
        rd_sel     = entries_q[read_pointer];
        rd_valid_d = rd_en;
        rd_hit_d   = rd_en && rd_sel.valid;
        rd_op_d    = rd_hit_d ? rd_sel.op       : '0;
        rd_a_d     = rd_hit_d ? rd_sel.a        : '0;
        rd_b_d     = rd_hit_d ? rd_sel.b        : '0;
        rd_res_d   = rd_hit_d ? rd_sel.result   : '0;
        rd_dz_d    = rd_hit_d ? rd_sel.div_zero : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            stg_valid_q <= 1'b0;
            stg_op_q    <= '0;
            stg_a_q     <= '0;
            stg_b_q     <= '0;
            stg_ptr_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
            rd_op_q     <= '0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            rd_res_q    <= '0;
            rd_dz_q     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            stg_valid_q <= stg_valid_d;
            stg_op_q    <= stg_op_d;
            stg_a_q     <= stg_a_d;
            stg_b_q     <= stg_b_d;
            stg_ptr_q   <= stg_ptr_d;
            rd_valid_q  <= rd_valid_d;
            rd_hit_q    <= rd_hit_d;
            rd_op_q     <= rd_op_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            rd_res_q    <= rd_res_d;
            rd_dz_q     <= rd_dz_d;
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
        end
    end

    assign wr_ready      = ready_q;
    assign rd_data_valid = rd_valid_q;
    assign rd_hit        = rd_hit_q;
    assign rd_opcode     = rd_op_q;
    assign rd_operand_a  = rd_a_q;
    assign rd_operand_b  = rd_b_q;
    assign rd_result     = rd_res_q;
    assign rd_div_zero   = rd_dz_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Bench for instr_register_pipe: directed vector table, corner-case sequences and
// random transactions checked against an array model using native signed arithmetic.
module tb_instr_register_pipe;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 32;
    localparam int unsigned AW  = 5;

    logic          clk;
    logic          reset_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    opcode;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic [AW-1:0] write_pointer;
    logic          clear;
    logic          rd_en;
    logic [AW-1:0] read_pointer;
    logic          rd_data_valid;
    logic          rd_hit;
    logic [2:0]    rd_opcode;
    logic [DW-1:0] rd_operand_a;
    logic [DW-1:0] rd_operand_b;
    logic [2*DW-1:0] rd_result;
    logic          rd_div_zero;

    instr_register_pipe #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .clear(clear), .rd_en(rd_en),
        .read_pointer(read_pointer), .rd_data_valid(rd_data_valid), .rd_hit(rd_hit),
        .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
        .rd_result(rd_result), .rd_div_zero(rd_div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic          m_valid [DEP];
    logic [2:0]    m_op    [DEP];
    logic [31:0]   m_a     [DEP];
    logic [31:0]   m_b     [DEP];
    logic [63:0]   m_res   [DEP];
    logic          m_dz    [DEP];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          wp;
        logic [63:0] res;
        logic        dz;
        int          low;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint la, lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (op)
            3'd0: return 64'(0);
            3'd1: return la;
            3'd2: return lb;
            3'd3: return la + lb;
            3'd4: return la - lb;
            3'd5: return la * lb;
            3'd6: return (lb == 0) ? 64'(0) : la / lb;
            default: return (lb == 0) ? 64'(0) : la % lb;
        endcase
    endfunction

    function automatic int ref_low(input logic [2:0] op, input logic [31:0] b);
        return (op >= 3'd6 && b != 32'd0) ? int'(DW) : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEP); i++) begin
            m_valid[i] = 1'b0; m_op[i] = '0; m_a[i] = '0; m_b[i] = '0;
            m_res[i] = '0; m_dz[i] = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEP); i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_commit(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int ptr);
        m_valid[ptr] = 1'b1;
        m_op[ptr]    = op;
        m_a[ptr]     = a;
        m_b[ptr]     = b;
        m_res[ptr]   = ref_res(op, a, b);
        m_dz[ptr]    = (op >= 3'd6) && (b == 32'd0);
    endtask

    // Called at a negedge; returns at a negedge after the entry has committed.
    task automatic write_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int ptr, output int low);
        int waits = 0;
        wr_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = AW'(ptr);
        while (!wr_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!wr_ready) begin
            chk("write_accept_timeout", 64'(0), 64'(1));
            wr_valid = 1'b0;
            low = -1;
            return;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        low = 0;
        while (!wr_ready && low < 100) begin
            @(negedge clk);
            low++;
        end
        @(negedge clk);
        model_commit(op, a, b, ptr);
    endtask

    task automatic do_read(input int ptr, output logic dv, output logic hit, output logic [2:0] op,
                           output logic [31:0] a, output logic [31:0] b, output logic [63:0] res,
                           output logic dz, output logic dv_next);
        rd_en = 1'b1; read_pointer = AW'(ptr);
        @(negedge clk);
        rd_en = 1'b0;
        dv = rd_data_valid; hit = rd_hit; op = rd_opcode; a = rd_operand_a;
        b = rd_operand_b; res = rd_result; dz = rd_div_zero;
        @(negedge clk);
        dv_next = rd_data_valid;
    endtask

    task automatic read_check(input int ptr, input string tag);
        logic dv, hit, dz, dvn, eh;
        logic [2:0] op;
        logic [31:0] a, b;
        logic [63:0] res;
        do_read(ptr, dv, hit, op, a, b, res, dz, dvn);
        eh = m_valid[ptr];
        chk($sformatf("%s rp%0d data_valid", tag, ptr), 64'(dv), 64'(1));
        chk($sformatf("%s rp%0d hit", tag, ptr), 64'(hit), 64'(eh));
        chk($sformatf("%s rp%0d opcode", tag, ptr), 64'(op), eh ? 64'(m_op[ptr]) : 64'(0));
        chk($sformatf("%s rp%0d operand_a", tag, ptr), 64'(a), eh ? 64'(m_a[ptr]) : 64'(0));
        chk($sformatf("%s rp%0d operand_b", tag, ptr), 64'(b), eh ? 64'(m_b[ptr]) : 64'(0));
        chk($sformatf("%s rp%0d result", tag, ptr), res, eh ? m_res[ptr] : 64'(0));
        chk($sformatf("%s rp%0d div_zero", tag, ptr), 64'(dz), eh ? 64'(m_dz[ptr]) : 64'(0));
        chk($sformatf("%s rp%0d valid_pulse", tag, ptr), 64'(dvn), 64'(0));
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        logic dv, hit, dz, dvn;
        logic [2:0] op;
        logic [31:0] a, b, a2, b2;
        logic [63:0] res;

        vecs[0]  = '{3'd3, -32'sd5,       32'd3,        4,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0};
        vecs[1]  = '{3'd5, 32'h7FFF_FFFF, 32'd2,        6,  64'h0000_0000_FFFF_FFFE, 1'b0, 0};
        vecs[2]  = '{3'd6, -32'sd7,       32'd2,        8,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 32};
        vecs[3]  = '{3'd7, -32'sd7,       32'd2,        9,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32};
        vecs[4]  = '{3'd6, 32'd9,         32'd0,        10, 64'h0,                   1'b1, 0};
        vecs[5]  = '{3'd7, 32'd9,         32'd0,        11, 64'h0,                   1'b1, 0};
        vecs[6]  = '{3'd4, 32'd3,         -32'sd4,      12, 64'h7,                   1'b0, 0};
        vecs[7]  = '{3'd0, 32'd5,         32'd6,        13, 64'h0,                   1'b0, 0};
        vecs[8]  = '{3'd2, 32'd1,         32'hFFFF_FFFF, 14, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0};
        vecs[9]  = '{3'd1, 32'h8000_0000, 32'd1,        15, 64'hFFFF_FFFF_8000_0000, 1'b0, 0};
        vecs[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 16, 64'h0000_0000_8000_0000, 1'b0, 32};
        vecs[11] = '{3'd7, 32'd7,         -32'sd2,      17, 64'h1,                   1'b0, 32};
        vecs[12] = '{3'd6, 32'd7,         -32'sd2,      18, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 32};
        vecs[13] = '{3'd5, 32'h8000_0000, 32'h8000_0000, 19, 64'h4000_0000_0000_0000, 1'b0, 0};

        reset_n = 1'b1; wr_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
        write_pointer = '0; clear = 1'b0; rd_en = 1'b0; read_pointer = '0;
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("reset wr_ready", 64'(wr_ready), 64'(0));
        chk("reset rd_data_valid", 64'(rd_data_valid), 64'(0));
        chk("reset rd_hit", 64'(rd_hit), 64'(0));
        chk("reset rd_result", rd_result, 64'(0));
        @(negedge clk); @(negedge clk);
        chk("reset held wr_ready", 64'(wr_ready), 64'(0));
        reset_n = 1'b1;
        #1 chk("release wr_ready before edge", 64'(wr_ready), 64'(0));
        @(negedge clk);
        chk("release wr_ready after edge", 64'(wr_ready), 64'(1));

        read_check(7, "unwritten");

        for (int i = 0; i < 14; i++) begin
            write_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wp, low);
            chk($sformatf("vec%0d busy_cycles", i), 64'(low), 64'(vecs[i].low));
            do_read(vecs[i].wp, dv, hit, op, a, b, res, dz, dvn);
            chk($sformatf("vec%0d hit", i), 64'(hit), 64'(1));
            chk($sformatf("vec%0d result", i), res, vecs[i].res);
            chk($sformatf("vec%0d div_zero", i), 64'(dz), 64'(vecs[i].dz));
            chk($sformatf("vec%0d opcode", i), 64'(op), 64'(vecs[i].op));
            chk($sformatf("vec%0d valid_pulse", i), {62'(0), dv, dvn}, 64'(2));
        end

        // 32 back-to-back PASSA writes
        for (int i = 0; i < int'(DEP); i++) begin
            a = $urandom;
            wr_valid = 1'b1; opcode = 3'd1; operand_a = a; operand_b = $urandom;
            write_pointer = AW'(i);
            chk($sformatf("b2b wr_ready %0d", i), 64'(wr_ready), 64'(1));
            model_commit(3'd1, a, operand_b, i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < int'(DEP); i++) read_check(i, "b2b");

        // read and commit to the same entry on one edge return the old contents
        write_op(3'd1, 32'h1234_5678, 32'd0, 20, low);
        a = $urandom; b = $urandom;
        wr_valid = 1'b1; opcode = 3'd2; operand_a = a; operand_b = b; write_pointer = AW'(20);
        @(negedge clk);
        wr_valid = 1'b0;
        read_check(20, "same_edge_old");
        model_commit(3'd2, a, b, 20);
        read_check(20, "same_edge_new");

        // two consecutive commits to one pointer
        a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
        wr_valid = 1'b1; opcode = 3'd3; operand_a = a; operand_b = b; write_pointer = AW'(21);
        @(negedge clk);
        chk("consec wr_ready", 64'(wr_ready), 64'(1));
        opcode = 3'd4; operand_a = a2; operand_b = b2;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        model_commit(3'd3, a, b, 21);
        model_commit(3'd4, a2, b2, 21);
        read_check(21, "consec");

        // clear coinciding with a commit to another entry
        write_op(3'd1, 32'd33, 32'd0, 3, low);
        wr_valid = 1'b1; opcode = 3'd3; operand_a = 32'd50; operand_b = 32'd5; write_pointer = AW'(5);
        @(negedge clk);
        wr_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        model_commit(3'd3, 32'd50, 32'd5, 5);
        read_check(3, "clear");
        read_check(5, "clear");
        read_check(4, "clear");

        // wr_valid held through a divide is taken only after wr_ready returns
        wr_valid = 1'b1; opcode = 3'd6; operand_a = 32'd100; operand_b = 32'd7; write_pointer = AW'(24);
        chk("held div wr_ready", 64'(wr_ready), 64'(1));
        @(negedge clk);
        opcode = 3'd3; operand_a = 32'd11; operand_b = 32'd22; write_pointer = AW'(25);
        low = 0;
        while (!wr_ready && low < 100) begin
            @(negedge clk);
            low++;
        end
        chk("held busy_cycles", 64'(low), 64'(DW));
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        model_commit(3'd6, 32'd100, 32'd7, 24);
        model_commit(3'd3, 32'd11, 32'd22, 25);
        read_check(24, "held");
        read_check(25, "held");

        // random transactions against the model
        for (int n = 0; n < 60; n++) begin
            int wp, sel;
            op = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 7);
            a = (sel == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            wp = $urandom_range(0, int'(DEP) - 1);
            write_op(op, a, b, wp, low);
            chk($sformatf("rand%0d busy_cycles", n), 64'(low), 64'(ref_low(op, b)));
            read_check(wp, "rand");
            if ($urandom_range(0, 9) == 0) begin
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                model_clear();
            end
            read_check($urandom_range(0, int'(DEP) - 1), "rand_other");
        end

        // reset asserted in the middle of a divide
        wr_valid = 1'b1; opcode = 3'd6; operand_a = 32'd1000; operand_b = 32'd3; write_pointer = AW'(26);
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_div wr_ready", 64'(wr_ready), 64'(0));
        reset_n = 1'b0;
        #1;
        chk("mid_div reset wr_ready", 64'(wr_ready), 64'(0));
        @(negedge clk); @(negedge clk);
        chk("mid_div held wr_ready", 64'(wr_ready), 64'(0));
        reset_n = 1'b1;
        #1 chk("mid_div release before edge", 64'(wr_ready), 64'(0));
        @(negedge clk);
        chk("mid_div release after edge", 64'(wr_ready), 64'(1));
        model_reset();
        for (int i = 0; i < int'(DEP); i++) read_check(i, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
